// File: rtl/mc_control_fsm.sv
// Multicycle CPU control unit: sequences one instruction over 2-5 cycles and
// decodes datapath selects, ALU control and write strobes from the current state.
module mc_control_fsm #(
    parameter int unsigned STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    output logic [2:0]         alucontrol,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic               iord,
    output logic               irwrite,
    output logic               memwrite,
    output logic               regwrite,
    output logic               regdst,
    output logic               memtoreg,
    output logic [1:0]         pcsrc,
    output logic               pcen,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state_dbg
);

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_e;

    state_e state_q, state_d;

    logic pcwrite_c, branch_c, irwrite_c, memwrite_c, regwrite_c, illegal_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore decode; funct and zero only matter in the EX states.
    always_comb begin
        state_d    = FETCH;
        alucontrol = ALU_ADD;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        iord       = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        pcsrc      = 2'b00;
        pcwrite_c  = 1'b0;
        branch_c   = 1'b0;
        irwrite_c  = 1'b0;
        memwrite_c = 1'b0;
        regwrite_c = 1'b0;
        illegal_c  = 1'b0;
        case (state_q)
            FETCH: begin
                irwrite_c = 1'b1;
                alusrcb   = 2'b01;
                pcwrite_c = 1'b1;
                state_d   = DECODE;
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JEX;
                    default: begin
                        illegal_c = 1'b1;
                        state_d   = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                iord    = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                regwrite_c = 1'b1;
                memtoreg   = 1'b1;
            end
            MEMWR: begin
                iord       = 1'b1;
                memwrite_c = 1'b1;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                state_d = RTYPEWB;
                case (funct)
                    6'b100000: alucontrol = ALU_ADD;
                    6'b100010: alucontrol = ALU_SUB;
                    6'b100100: alucontrol = ALU_AND;
                    6'b100101: alucontrol = ALU_OR;
                    6'b101010: alucontrol = ALU_SLT;
                    default:   illegal_c  = 1'b1;
                endcase
            end
            RTYPEWB: begin
                regwrite_c = 1'b1;
                regdst     = 1'b1;
            end
            BEQEX: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                branch_c   = 1'b1;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = ADDIWB;
            end
            ADDIWB: begin
                regwrite_c = 1'b1;
            end
            JEX: begin
                pcsrc     = 2'b10;
                pcwrite_c = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    // Strobes are held low for the whole reset, even though FETCH would assert some.
    assign irwrite    = irwrite_c  & rst_n;
    assign memwrite   = memwrite_c & rst_n;
    assign regwrite   = regwrite_c & rst_n;
    assign illegal_op = illegal_c  & rst_n;
    assign pcen       = (pcwrite_c | (branch_c & zero)) & rst_n;
    assign state_dbg  = STATE_W'(state_q);

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: per-instruction step model of the control outputs,
// checked every cycle, plus literal instruction-length and reset expectations.
module tb_mc_control_fsm;

    logic       clk;
    logic       rst_n;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic [2:0] alucontrol;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       iord, irwrite, memwrite, regwrite, regdst, memtoreg;
    logic [1:0] pcsrc;
    logic       pcen, illegal_op;
    logic [3:0] state_dbg;

    mc_control_fsm #(.STATE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
        .alucontrol(alucontrol), .alusrca(alusrca), .alusrcb(alusrcb),
        .iord(iord), .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite),
        .regdst(regdst), .memtoreg(memtoreg), .pcsrc(pcsrc), .pcen(pcen),
        .illegal_op(illegal_op), .state_dbg(state_dbg)
    );

    typedef struct packed {
        logic [2:0] alucontrol;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       iord;
        logic       irwrite;
        logic       memwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic [1:0] pcsrc;
        logic       pcen;
        logic       illegal;
        logic       fetch;
    } exp_t;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q;
    logic exp_valid = 1'b0;
    int   cyc = 0;
    int   last_len = 0;
    int   pending_lit = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int lat(input logic [5:0] o);
        case (o)
            6'b100011: return 5;
            6'b101011, 6'b000000, 6'b001000: return 4;
            6'b000100, 6'b000010: return 3;
            default: return 2;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input logic [5:0] f);
        case (f)
            6'b100000: return 4'b0000;
            6'b100010: return 4'b0001;
            6'b100100: return 4'b0010;
            6'b100101: return 4'b0011;
            6'b101010: return 4'b0101;
            default:   return 4'b1000;
        endcase
    endfunction

    // Expected outputs for step s (0 = fetch) of the instruction (o, f) with flag z.
    function automatic exp_t model(input logic [5:0] o, input logic [5:0] f,
                                   input logic z, input int s);
        exp_t e;
        logic [3:0] a;
        e = '0;
        e.fetch = (s == 0);
        if (s == 0) begin
            e.irwrite = 1'b1; e.alusrcb = 2'b01; e.pcen = 1'b1;
        end else if (s == 1) begin
            e.alusrcb = 2'b11;
            e.illegal = (lat(o) == 2);
        end else if (o == 6'b100011 || o == 6'b101011) begin
            if (s == 2) begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
            else if (s == 3) begin
                e.iord = 1'b1;
                e.memwrite = (o == 6'b101011);
            end else begin
                e.regwrite = 1'b1; e.memtoreg = 1'b1;
            end
        end else if (o == 6'b000000) begin
            if (s == 2) begin
                a = alu_of(f);
                e.alusrca = 1'b1;
                e.alucontrol = a[2:0];
                e.illegal = a[3];
            end else begin
                e.regwrite = 1'b1; e.regdst = 1'b1;
            end
        end else if (o == 6'b000100) begin
            e.alusrca = 1'b1; e.alucontrol = 3'b001; e.pcsrc = 2'b01; e.pcen = z;
        end else if (o == 6'b001000) begin
            if (s == 2) begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
            else e.regwrite = 1'b1;
        end else begin
            e.pcsrc = 2'b10; e.pcen = 1'b1;
        end
        return e;
    endfunction

    // Cycle counter from one FETCH to the next.
    always @(negedge clk) begin
        #1;
        if (!rst_n) cyc = 0;
        else if (state_dbg == 4'd0) begin
            if (cyc != 0) last_len = cyc;
            cyc = 1;
        end else cyc++;
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        #2;
        if (exp_valid) begin
            chk("alucontrol", 32'(alucontrol), 32'(exp_q.alucontrol));
            chk("alusrca",    32'(alusrca),    32'(exp_q.alusrca));
            chk("alusrcb",    32'(alusrcb),    32'(exp_q.alusrcb));
            chk("iord",       32'(iord),       32'(exp_q.iord));
            chk("irwrite",    32'(irwrite),    32'(exp_q.irwrite));
            chk("memwrite",   32'(memwrite),   32'(exp_q.memwrite));
            chk("regwrite",   32'(regwrite),   32'(exp_q.regwrite));
            chk("regdst",     32'(regdst),     32'(exp_q.regdst));
            chk("memtoreg",   32'(memtoreg),   32'(exp_q.memtoreg));
            chk("pcsrc",      32'(pcsrc),      32'(exp_q.pcsrc));
            chk("pcen",       32'(pcen),       32'(exp_q.pcen));
            chk("illegal_op", 32'(illegal_op), 32'(exp_q.illegal));
            chk("in_fetch",   32'(state_dbg == 4'd0), 32'(exp_q.fetch));
            chk("mem_reg_excl", 32'(memwrite & regwrite), 32'd0);
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_state"},    32'(state_dbg),  32'd0);
        chk({tag, "_irwrite"},  32'(irwrite),    32'd0);
        chk({tag, "_memwrite"}, 32'(memwrite),   32'd0);
        chk({tag, "_regwrite"}, 32'(regwrite),   32'd0);
        chk({tag, "_pcen"},     32'(pcen),       32'd0);
        chk({tag, "_illegal"},  32'(illegal_op), 32'd0);
        chk({tag, "_alucontrol"}, 32'(alucontrol), 32'd0);
        chk({tag, "_alusrca"},  32'(alusrca),    32'd0);
        chk({tag, "_alusrcb"},  32'(alusrcb),    32'd1);
        chk({tag, "_iord"},     32'(iord),       32'd0);
        chk({tag, "_pcsrc"},    32'(pcsrc),      32'd0);
    endtask

    // Run one instruction; lit is its hand-computed length, abort_at a step to reset in (-1 none).
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                             input int lit, input int abort_at);
        int n;
        n = lat(o);
        for (int s = 0; s < n; s++) begin
            @(negedge clk);
            op = o; funct = f; zero = z;
            exp_q = model(o, f, z, s);
            exp_valid = 1'b1;
            #3;
            if (s == 0 && pending_lit != 0) chk("instr_len", 32'(last_len), 32'(pending_lit));
            if (s == abort_at) begin
                rst_n = 1'b0;
                exp_valid = 1'b0;
                #1;
                check_reset_outputs("midreset");
                @(posedge clk);
                @(posedge clk);
                #2 rst_n = 1'b1;
                pending_lit = 0;
                return;
            end
        end
        pending_lit = lit;
    endtask

    initial begin
        rst_n = 1'b0; op = '0; funct = '0; zero = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #3 check_reset_outputs("reset");
        @(posedge clk);
        #2 rst_n = 1'b1;

        run_instr(6'b100011, 6'b000000, 1'b0, 5, -1);
        run_instr(6'b000000, 6'b100000, 1'b0, 4, -1);
        run_instr(6'b000000, 6'b100010, 1'b1, 4, -1);
        run_instr(6'b000000, 6'b100100, 1'b0, 4, -1);
        run_instr(6'b000000, 6'b100101, 1'b0, 4, -1);
        run_instr(6'b000000, 6'b101010, 1'b0, 4, -1);
        run_instr(6'b000100, 6'b000000, 1'b1, 3, -1);
        run_instr(6'b000100, 6'b000000, 1'b0, 3, -1);
        run_instr(6'b111111, 6'b000000, 1'b1, 2, -1);
        run_instr(6'b000000, 6'b000111, 1'b0, 4, -1);
        run_instr(6'b101011, 6'b000000, 1'b0, 4, -1);
        run_instr(6'b001000, 6'b000000, 1'b1, 4, -1);
        run_instr(6'b000010, 6'b000000, 1'b0, 3, -1);
        run_instr(6'b101011, 6'b000000, 1'b0, 4, 3);
        run_instr(6'b001000, 6'b000000, 1'b0, 4, -1);
        run_instr(6'b000010, 6'b000000, 1'b1, 3, -1);

        @(negedge clk);
        exp_q = model(6'b000000, 6'b000000, 1'b0, 0);
        exp_valid = 1'b1;
        #3 chk("instr_len", 32'(last_len), 32'(pending_lit));
        exp_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
